// File: rtl/write_back_buffer.sv
// Write-back buffer: accumulates ALU result blocks into a word array and drains the
// array to DDR3 as an Avalon write master, one 128-bit beat per row segment.
module write_back_buffer #(
    parameter int BLOCK_SIZE = 64,
    parameter int ROW_WORDS  = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      wb_reset,
    input  logic                      accumulate,
    input  logic [32*BLOCK_SIZE-1:0]  block,
    input  logic                      store_ddr,
    input  logic [25:0]               start_address,
    input  logic [9:0]                stride,
    input  logic [9:0]                rows,
    input  logic [10:0]               block_num,
    output logic                      ready,
    input  logic                      local_init_done,
    input  logic                      avl_wait_request_n,
    input  logic                      avl_readdatavalid,
    input  logic [127:0]              avl_readdata,
    output logic [25:0]               avl_address,
    output logic [127:0]              avl_writedata,
    output logic                      avl_write,
    output logic                      avl_read,
    output logic                      avl_burstbegin,
    output logic [1:0]                fsm_state
);
    localparam int MAX_ROWS = BLOCK_SIZE / ROW_WORDS;
    localparam int BPR      = ROW_WORDS / 4;
    localparam int NBEATS   = BLOCK_SIZE / 4;
    localparam int BEAT_W   = (BPR > 1) ? $clog2(BPR) : 1;
    localparam int IDX_W    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BPR - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t state, next_state;

    logic [31:0]       acc [BLOCK_SIZE];
    logic [25:0]       lat_start;
    logic [9:0]        lat_stride;
    logic [9:0]        lat_rows;
    logic [10:0]       lat_block_num;
    logic [9:0]        eff_rows;
    logic [9:0]        eff_rows_q;
    logic [9:0]        row_cnt;
    logic [BEAT_W-1:0] beat_cnt;
    logic [IDX_W-1:0]  beat_idx;
    logic [IDX_W-1:0]  next_idx;
    logic [25:0]       row_base;
    logic [25:0]       base_off;
    logic [25:0]       base;
    logic [127:0]      next_data;
    logic              accept;
    logic              last_beat;
    logic              abort_q;
    logic              store_go;
    logic              acc_en;
    logic              clear_arr;
    logic              unused_inputs;

    assign unused_inputs = ^{avl_readdatavalid, avl_readdata};
    assign avl_read      = 1'b0;
    assign fsm_state     = state;

    // Avalon handshake: avl_write is the valid and avl_wait_request_n the ready; a beat
    // transfers on a cycle where both are 1, otherwise address/data/write stay frozen.
    assign accept    = avl_write & avl_wait_request_n;
    assign last_beat = (beat_cnt == LAST_BEAT) && (row_cnt == eff_rows_q - 10'd1);
    assign store_go  = (state == IDLE) && store_ddr && ready && !wb_reset;
    assign acc_en    = (state == IDLE) && accumulate && !wb_reset;

    always_comb begin
        eff_rows = (lat_rows > 10'(MAX_ROWS)) ? 10'(MAX_ROWS) : lat_rows;
        base_off = 26'(32'(lat_block_num) * 32'(eff_rows) * 32'(lat_stride));
        base     = lat_start + base_off;
    end

    always_comb begin
        next_idx  = (state == LATCH) ? '0 : beat_idx + IDX_W'(1);
        next_data = '0;
        for (int k = 0; k < 4; k++) begin
            next_data[32*k +: 32] = acc[{next_idx, 2'(k)}];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        clear_arr  = 1'b0;
        case (state)
            IDLE: begin
                if (wb_reset) begin
                    clear_arr = 1'b1;
                end else if (store_go) begin
                    next_state = LATCH;
                end
            end
            LATCH: begin
                if (wb_reset) begin
                    next_state = IDLE;
                    clear_arr  = 1'b1;
                end else if (eff_rows == 10'd0) begin
                    next_state = IDLE;
                end else begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                // An abort request only takes effect once the pending beat is accepted.
                if (accept && (last_beat || abort_q || wb_reset)) begin
                    next_state = IDLE;
                    clear_arr  = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready          <= 1'b0;
            lat_start      <= '0;
            lat_stride     <= '0;
            lat_rows       <= '0;
            lat_block_num  <= '0;
            eff_rows_q     <= '0;
            row_cnt        <= '0;
            beat_cnt       <= '0;
            beat_idx       <= '0;
            row_base       <= '0;
            abort_q        <= 1'b0;
            avl_address    <= '0;
            avl_writedata  <= '0;
            avl_write      <= 1'b0;
            avl_burstbegin <= 1'b0;
        end else begin
            ready <= (next_state == IDLE) && local_init_done;
            if (store_go) begin
                lat_start     <= start_address;
                lat_stride    <= stride;
                lat_rows      <= rows;
                lat_block_num <= block_num;
            end
            if (state == LATCH && next_state == WRITE) begin
                eff_rows_q     <= eff_rows;
                row_base       <= base;
                avl_address    <= base;
                row_cnt        <= '0;
                beat_cnt       <= '0;
                beat_idx       <= '0;
                abort_q        <= 1'b0;
                avl_writedata  <= next_data;
                avl_write      <= 1'b1;
                avl_burstbegin <= 1'b1;
            end else if (state == WRITE) begin
                if (wb_reset) begin
                    abort_q <= 1'b1;
                end
                if (accept) begin
                    if (next_state == IDLE) begin
                        avl_write      <= 1'b0;
                        avl_burstbegin <= 1'b0;
                        abort_q        <= 1'b0;
                    end else begin
                        beat_idx      <= next_idx;
                        avl_writedata <= next_data;
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt    <= '0;
                            row_cnt     <= row_cnt + 10'd1;
                            row_base    <= row_base + 26'(lat_stride);
                            avl_address <= row_base + 26'(lat_stride);
                        end else begin
                            beat_cnt    <= beat_cnt + BEAT_W'(1);
                            avl_address <= row_base + 26'(beat_cnt) + 26'd1;
                        end
                    end
                end
            end
        end
    end

    // Array is only modified in IDLE, so beat data can be fetched from it while draining.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BLOCK_SIZE; i++) acc[i] <= '0;
        end else if (clear_arr) begin
            for (int i = 0; i < BLOCK_SIZE; i++) acc[i] <= '0;
        end else if (acc_en) begin
            for (int i = 0; i < BLOCK_SIZE; i++) acc[i] <= acc[i] + block[32*i +: 32];
        end
    end

endmodule

// File: tb/tb_write_back_buffer.sv
// Directed bench for write_back_buffer: accumulation, row-strided DDR drain,
// backpressure, boundaries, aborts and ignored strobes.
module tb_write_back_buffer;
    localparam int BS = 64;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            wb_reset = 1'b0;
    logic            accumulate = 1'b0;
    logic [32*BS-1:0] block = '0;
    logic            store_ddr = 1'b0;
    logic [25:0]     start_address = '0;
    logic [9:0]      stride = '0;
    logic [9:0]      rows = '0;
    logic [10:0]     block_num = '0;
    logic            ready;
    logic            local_init_done = 1'b1;
    logic            avl_wait_request_n = 1'b1;
    logic            avl_readdatavalid = 1'b0;
    logic [127:0]    avl_readdata = '0;
    logic [25:0]     avl_address;
    logic [127:0]    avl_writedata;
    logic            avl_write;
    logic            avl_read;
    logic            avl_burstbegin;
    logic [1:0]      fsm_state;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int proto_bad = 0;

    logic [25:0]  got_addr[$];
    logic [127:0] got_data[$];
    int           got_cyc[$];
    logic [25:0]  stall_addr[$];
    logic [127:0] stall_data[$];
    logic [25:0]  exp_addr_q[$];
    logic [127:0] exp_data_q[$];

    write_back_buffer dut (
        .clk(clk), .reset_n(reset_n), .wb_reset(wb_reset), .accumulate(accumulate),
        .block(block), .store_ddr(store_ddr), .start_address(start_address),
        .stride(stride), .rows(rows), .block_num(block_num), .ready(ready),
        .local_init_done(local_init_done), .avl_wait_request_n(avl_wait_request_n),
        .avl_readdatavalid(avl_readdatavalid), .avl_readdata(avl_readdata),
        .avl_address(avl_address), .avl_writedata(avl_writedata), .avl_write(avl_write),
        .avl_read(avl_read), .avl_burstbegin(avl_burstbegin), .fsm_state(fsm_state)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // Beat monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (reset_n) begin
            if (avl_burstbegin !== avl_write || avl_read !== 1'b0) proto_bad++;
            if (avl_write && avl_wait_request_n) begin
                got_addr.push_back(avl_address);
                got_data.push_back(avl_writedata);
                got_cyc.push_back(cyc);
            end else if (avl_write) begin
                stall_addr.push_back(avl_address);
                stall_data.push_back(avl_writedata);
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_block_ramp(input logic [31:0] off);
        for (int i = 0; i < BS; i++) block[32*i +: 32] = off + 32'(i);
    endtask

    task automatic do_accumulate();
        accumulate = 1'b1;
        tick();
        accumulate = 1'b0;
    endtask

    function automatic logic [127:0] beat4(input logic [31:0] w0);
        return {w0 + 32'd3, w0 + 32'd2, w0 + 32'd1, w0};
    endfunction

    task automatic run_store(input logic [25:0] sa, input logic [9:0] st, input logic [9:0] rw,
                             input logic [10:0] bn, input int stall_off, input int stall_len,
                             input int abort_off, input int ign_off,
                             output int issue_c, output int done_c, output bit timed_out);
        start_address = sa;
        stride = st;
        rows = rw;
        block_num = bn;
        store_ddr = 1'b1;
        issue_c = cyc;
        done_c = 0;
        timed_out = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            store_ddr = (k == ign_off);
            accumulate = (k == ign_off);
            wb_reset = (k == abort_off);
            avl_wait_request_n = !(k >= stall_off && k < stall_off + stall_len);
            if (ready) begin
                done_c = cyc;
                timed_out = 1'b0;
                break;
            end
        end
        store_ddr = 1'b0;
        accumulate = 1'b0;
        wb_reset = 1'b0;
        avl_wait_request_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        local_init_done = 1'b1;
        avl_readdata = {$urandom, $urandom, $urandom, $urandom};
        avl_readdatavalid = 1'($urandom_range(0, 1));
        repeat (3) tick();
        n_checks++;
        if ({avl_write, avl_burstbegin, avl_read, avl_address, avl_writedata} !== '0) begin
            n_fail++;
            $display("FAIL reset_avl: got addr=%h data=%h wr=%b bb=%b rd=%b, expected all 0",
                     avl_address, avl_writedata, avl_write, avl_burstbegin, avl_read);
        end
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 0", ready);
        end
        n_checks++;
        if (fsm_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected 0", fsm_state);
        end
        reset_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_release: got %b expected 1", ready);
        end
    endtask

    task automatic test_accumulate_store();
        int b0, ic, dc, n;
        bit to;
        set_block_ramp(32'd0);
        do_accumulate();
        do_accumulate();
        block = '0;
        block[31:0] = 32'hFFFF_FFFF;
        do_accumulate();
        block[31:0] = 32'd2;
        do_accumulate();
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_addr_q = '{26'h120, 26'h121, 26'h130, 26'h131};
        exp_data_q = '{{32'd6, 32'd4, 32'd2, 32'd1}, {32'd14, 32'd12, 32'd10, 32'd8},
                       {32'd22, 32'd20, 32'd18, 32'd16}, {32'd30, 32'd28, 32'd26, 32'd24}};
        b0 = got_addr.size();
        run_store(26'h100, 10'd16, 10'd2, 11'd1, 0, 0, -1, -1, ic, dc, to);
        n = got_addr.size() - b0;
        n_checks++;
        if (to || n != 4) begin
            n_fail++;
            $display("FAIL store_count: got %0d beats (timeout=%b) expected 4", n, to);
        end
        for (int i = 0; i < 4 && i < n; i++) begin
            n_checks++;
            if (got_addr[b0+i] !== exp_addr_q[i] || got_data[b0+i] !== exp_data_q[i]) begin
                n_fail++;
                $display("FAIL store_beat%0d: got %h/%h expected %h/%h", i, got_addr[b0+i],
                         got_data[b0+i], exp_addr_q[i], exp_data_q[i]);
            end
        end
        if (n == 4) begin
            n_checks++;
            if (got_cyc[b0] - ic != 2 || got_cyc[b0+3] - got_cyc[b0] != 3 || dc - got_cyc[b0+3] != 1) begin
                n_fail++;
                $display("FAIL store_timing: got first=%0d span=%0d ready=%0d expected 2/3/1",
                         got_cyc[b0] - ic, got_cyc[b0+3] - got_cyc[b0], dc - got_cyc[b0+3]);
            end
        end
        b0 = got_addr.size();
        run_store(26'h0, 10'd16, 10'd1, 11'd0, 0, 0, -1, -1, ic, dc, to);
        n = got_addr.size() - b0;
        n_checks++;
        if (to || n != 2 || got_addr[b0+1] !== 26'h1 || got_data[b0] !== '0 || got_data[b0+1] !== '0) begin
            n_fail++;
            $display("FAIL store_cleared: got %0d beats (timeout=%b), expected 2 zero beats at 0,1", n, to);
        end
    endtask

    task automatic test_backpressure();
        int b0, s0, ic, dc, n;
        bit to;
        set_block_ramp(32'h10);
        do_accumulate();
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_addr_q = '{26'h40, 26'h41, 26'h44, 26'h45};
        exp_data_q = '{beat4(32'h10), beat4(32'h14), beat4(32'h18), beat4(32'h1C)};
        b0 = got_addr.size();
        s0 = stall_addr.size();
        run_store(26'h40, 10'd4, 10'd2, 11'd0, 3, 3, -1, -1, ic, dc, to);
        n = got_addr.size() - b0;
        n_checks++;
        if (to || n != 4) begin
            n_fail++;
            $display("FAIL bp_count: got %0d beats (timeout=%b) expected 4", n, to);
        end
        for (int i = 0; i < 4 && i < n; i++) begin
            n_checks++;
            if (got_addr[b0+i] !== exp_addr_q[i] || got_data[b0+i] !== exp_data_q[i]) begin
                n_fail++;
                $display("FAIL bp_beat%0d: got %h/%h expected %h/%h", i, got_addr[b0+i],
                         got_data[b0+i], exp_addr_q[i], exp_data_q[i]);
            end
        end
        n_checks++;
        if (stall_addr.size() - s0 != 3) begin
            n_fail++;
            $display("FAIL bp_stalls: got %0d stalled cycles expected 3", stall_addr.size() - s0);
        end
        for (int i = s0; i < stall_addr.size(); i++) begin
            n_checks++;
            if (stall_addr[i] !== 26'h41 || stall_data[i] !== beat4(32'h14)) begin
                n_fail++;
                $display("FAIL bp_hold: got %h/%h expected 0000041/%h", stall_addr[i], stall_data[i],
                         beat4(32'h14));
            end
        end
        n_checks++;
        if (dc - ic != 9) begin
            n_fail++;
            $display("FAIL bp_total: got %0d cycles expected 9", dc - ic);
        end
    endtask

    task automatic test_rows_zero();
        int b0, ic, dc;
        bit to;
        b0 = got_addr.size();
        run_store(26'h300, 10'd4, 10'd0, 11'd3, 0, 0, -1, -1, ic, dc, to);
        n_checks++;
        if (to || got_addr.size() != b0 || dc - ic != 2) begin
            n_fail++;
            $display("FAIL rows_zero: got %0d beats, ready after %0d (timeout=%b), expected 0 and 2",
                     got_addr.size() - b0, dc - ic, to);
        end
    endtask

    task automatic test_clamp();
        int b0, ic, dc, n;
        bit to;
        exp_addr_q.delete();
        exp_data_q.delete();
        for (int r = 0; r < 8; r++) begin
            for (int b = 0; b < 2; b++) begin
                exp_addr_q.push_back(26'h220 + 26'(2*r + b));
                exp_data_q.push_back(beat4(32'h100 + 32'(8*r + 4*b)));
            end
        end
        set_block_ramp(32'h100);
        accumulate = 1'b1;
        b0 = got_addr.size();
        run_store(26'h200, 10'd2, 10'd20, 11'd2, 0, 0, -1, -1, ic, dc, to);
        n = got_addr.size() - b0;
        n_checks++;
        if (to || n != 16) begin
            n_fail++;
            $display("FAIL clamp_count: got %0d beats (timeout=%b) expected 16", n, to);
        end
        for (int i = 0; i < 16 && i < n; i++) begin
            n_checks++;
            if (got_addr[b0+i] !== exp_addr_q[i] || got_data[b0+i] !== exp_data_q[i]) begin
                n_fail++;
                $display("FAIL clamp_beat%0d: got %h/%h expected %h/%h", i, got_addr[b0+i],
                         got_data[b0+i], exp_addr_q[i], exp_data_q[i]);
            end
        end
    endtask

    task automatic test_wrap();
        int b0, ic, dc, n;
        bit to;
        set_block_ramp(32'h40);
        do_accumulate();
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_addr_q = '{26'h3FF_FFFF, 26'h0, 26'h0, 26'h1};
        exp_data_q = '{beat4(32'h40), beat4(32'h44), beat4(32'h48), beat4(32'h4C)};
        b0 = got_addr.size();
        run_store(26'h3FF_FFFF, 10'd1, 10'd2, 11'd0, 0, 0, -1, -1, ic, dc, to);
        n = got_addr.size() - b0;
        n_checks++;
        if (to || n != 4) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d beats (timeout=%b) expected 4", n, to);
        end
        for (int i = 0; i < 4 && i < n; i++) begin
            n_checks++;
            if (got_addr[b0+i] !== exp_addr_q[i] || got_data[b0+i] !== exp_data_q[i]) begin
                n_fail++;
                $display("FAIL wrap_beat%0d: got %h/%h expected %h/%h", i, got_addr[b0+i],
                         got_data[b0+i], exp_addr_q[i], exp_data_q[i]);
            end
        end
        b0 = got_addr.size();
        run_store(26'h3FF_FFF0, 10'h10, 10'd1, 11'd1, 0, 0, -1, -1, ic, dc, to);
        n = got_addr.size() - b0;
        n_checks++;
        if (to || n != 2 || got_addr[b0] !== 26'h0 || got_addr[b0+1] !== 26'h1) begin
            n_fail++;
            $display("FAIL wrap_base: got %0d beats (timeout=%b), expected beats at 0000000,0000001", n, to);
        end
    endtask

    task automatic test_abort();
        int b0, ic, dc, n;
        bit to;
        set_block_ramp(32'h20);
        do_accumulate();
        b0 = got_addr.size();
        run_store(26'h80, 10'd4, 10'd2, 11'd0, 3, 3, 4, -1, ic, dc, to);
        repeat (4) tick();
        n = got_addr.size() - b0;
        n_checks++;
        if (to || n != 2 || dc - ic != 7) begin
            n_fail++;
            $display("FAIL abort_count: got %0d beats, ready after %0d (timeout=%b), expected 2 and 7",
                     n, dc - ic, to);
        end
        if (n >= 2) begin
            n_checks++;
            if (got_addr[b0+1] !== 26'h81 || got_data[b0+1] !== beat4(32'h24)) begin
                n_fail++;
                $display("FAIL abort_held_beat: got %h/%h expected 0000081/%h", got_addr[b0+1],
                         got_data[b0+1], beat4(32'h24));
            end
        end
        b0 = got_addr.size();
        run_store(26'h90, 10'd4, 10'd1, 11'd0, 0, 0, -1, -1, ic, dc, to);
        n = got_addr.size() - b0;
        n_checks++;
        if (to || n != 2 || got_data[b0] !== '0 || got_data[b0+1] !== '0) begin
            n_fail++;
            $display("FAIL abort_cleared: got %0d beats (timeout=%b), expected 2 zero beats", n, to);
        end
    endtask

    task automatic test_ignored();
        int b0, ic, dc, n;
        bit to;
        set_block_ramp(32'h30);
        do_accumulate();
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_addr_q = '{26'hC0, 26'hC1, 26'hC4, 26'hC5};
        exp_data_q = '{beat4(32'h30), beat4(32'h34), beat4(32'h38), beat4(32'h3C)};
        b0 = got_addr.size();
        run_store(26'hC0, 10'd4, 10'd2, 11'd0, 0, 0, -1, 3, ic, dc, to);
        repeat (6) tick();
        n = got_addr.size() - b0;
        n_checks++;
        if (to || n != 4) begin
            n_fail++;
            $display("FAIL ignored_count: got %0d beats (timeout=%b) expected 4", n, to);
        end
        for (int i = 0; i < 4 && i < n; i++) begin
            n_checks++;
            if (got_addr[b0+i] !== exp_addr_q[i] || got_data[b0+i] !== exp_data_q[i]) begin
                n_fail++;
                $display("FAIL ignored_beat%0d: got %h/%h expected %h/%h", i, got_addr[b0+i],
                         got_data[b0+i], exp_addr_q[i], exp_data_q[i]);
            end
        end
    endtask

    task automatic test_init_done();
        int b0;
        local_init_done = 1'b0;
        tick();
        tick();
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL init_ready_low: got %b expected 0", ready);
        end
        b0 = got_addr.size();
        rows = 10'd1;
        store_ddr = 1'b1;
        tick();
        store_ddr = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (got_addr.size() != b0 || fsm_state !== 2'd0) begin
            n_fail++;
            $display("FAIL init_store_ignored: got %0d beats state %0d expected 0 beats state 0",
                     got_addr.size() - b0, fsm_state);
        end
        local_init_done = 1'b1;
        tick();
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL init_ready_back: got %b expected 1", ready);
        end
    endtask

    task automatic test_protocol();
        n_checks++;
        if (proto_bad != 0) begin
            n_fail++;
            $display("FAIL protocol: got %0d cycles with burstbegin!=write or read!=0, expected 0", proto_bad);
        end
    endtask

    initial begin
        test_reset();
        test_accumulate_store();
        test_backpressure();
        test_rows_zero();
        test_clamp();
        test_wrap();
        test_abort();
        test_ignored();
        test_init_done();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
